// File: rtl/id_stage_pkg.sv
// Shared RISC-V decode definitions for the instruction-decode stage:
// opcodes, ALU class codes, immediate/operand selectors and a control decoder.
package id_stage_pkg;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;

    // ALU class codes; bit 7 flags a 32-bit word operation on RV64
    localparam logic [7:0] ALUOP_NOP       = 8'h00;
    localparam logic [7:0] ALUOP_ARITH     = 8'h01;
    localparam logic [7:0] ALUOP_ARITH_IMM = 8'h02;
    localparam logic [7:0] ALUOP_LUI       = 8'h03;
    localparam logic [7:0] ALUOP_AUIPC     = 8'h04;
    localparam logic [7:0] ALUOP_LOAD      = 8'h05;
    localparam logic [7:0] ALUOP_STORE     = 8'h06;
    localparam logic [7:0] ALUOP_WORD      = 8'h80;

    typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_U} imm_type_e;
    typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC, OP1_IMM} op1_sel_e;
    typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM} op2_sel_e;

    typedef struct packed {
        logic      legal;
        logic [7:0] aluop;
        imm_type_e imm_type;
        op1_sel_e  op1_sel;
        op2_sel_e  op2_sel;
        logic      use_rs1;
        logic      use_rs2;
        logic      writes_rd;
        logic      mem;
        logic      store;
    } dec_ctrl_t;

    function automatic dec_ctrl_t decode_ctrl(input logic [6:0] opc, input logic word_ok);
        dec_ctrl_t d;
        d.legal     = 1'b0;
        d.aluop     = ALUOP_NOP;
        d.imm_type  = IMM_NONE;
        d.op1_sel   = OP1_ZERO;
        d.op2_sel   = OP2_ZERO;
        d.use_rs1   = 1'b0;
        d.use_rs2   = 1'b0;
        d.writes_rd = 1'b0;
        d.mem       = 1'b0;
        d.store     = 1'b0;
        case (opc)
            OPC_OP, OPC_OP_32: begin
                if (opc == OPC_OP || word_ok) begin
                    d.legal     = 1'b1;
                    d.aluop     = (opc == OPC_OP_32) ? (ALUOP_ARITH | ALUOP_WORD) : ALUOP_ARITH;
                    d.op1_sel   = OP1_RS1;
                    d.op2_sel   = OP2_RS2;
                    d.use_rs1   = 1'b1;
                    d.use_rs2   = 1'b1;
                    d.writes_rd = 1'b1;
                end
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                if (opc == OPC_OP_IMM || word_ok) begin
                    d.legal     = 1'b1;
                    d.aluop     = (opc == OPC_OP_IMM_32) ? (ALUOP_ARITH_IMM | ALUOP_WORD) : ALUOP_ARITH_IMM;
                    d.imm_type  = IMM_I;
                    d.op1_sel   = OP1_RS1;
                    d.op2_sel   = OP2_IMM;
                    d.use_rs1   = 1'b1;
                    d.writes_rd = 1'b1;
                end
            end
            OPC_LUI: begin
                d.legal     = 1'b1;
                d.aluop     = ALUOP_LUI;
                d.imm_type  = IMM_U;
                d.op1_sel   = OP1_IMM;
                d.writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                d.legal     = 1'b1;
                d.aluop     = ALUOP_AUIPC;
                d.imm_type  = IMM_U;
                d.op1_sel   = OP1_PC;
                d.op2_sel   = OP2_IMM;
                d.writes_rd = 1'b1;
            end
            OPC_LOAD: begin
                d.legal     = 1'b1;
                d.aluop     = ALUOP_LOAD;
                d.imm_type  = IMM_I;
                d.op1_sel   = OP1_RS1;
                d.op2_sel   = OP2_IMM;
                d.use_rs1   = 1'b1;
                d.writes_rd = 1'b1;
                d.mem       = 1'b1;
            end
            OPC_STORE: begin
                d.legal    = 1'b1;
                d.aluop    = ALUOP_STORE;
                d.imm_type = IMM_S;
                d.op1_sel  = OP1_RS1;
                d.op2_sel  = OP2_IMM;
                d.use_rs1  = 1'b1;
                d.use_rs2  = 1'b1;
                d.mem      = 1'b1;
                d.store    = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Priority forwarding select for one source operand: x0 reads zero, otherwise
// the lowest-indexed (youngest) matching forward port wins over the regfile.
module id_fwd_mux
    import id_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NFWD = 2
) (
    input  logic [4:0]           i_addr,
    input  logic [NFWD-1:0]      i_fwd_en,
    input  logic [5*NFWD-1:0]    i_fwd_addr,
    input  logic [XLEN*NFWD-1:0] i_fwd_data,
    input  logic [XLEN-1:0]      i_rf_data,
    output logic [XLEN-1:0]      o_data
);

    logic [NFWD-1:0] w_hit;

    for (genvar gi = 0; gi < NFWD; gi++) begin : g_hit
        assign w_hit[gi] = i_fwd_en[gi] && (i_fwd_addr[gi*5 +: 5] == i_addr);
    end

    // Walk from oldest to youngest so the lowest matching index ends up selected
    always_comb begin
        o_data = i_rf_data;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (w_hit[k]) o_data = i_fwd_data[k*XLEN +: XLEN];
        end
        if (i_addr == 5'd0) o_data = '0;
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decodes one RV32/RV64 integer instruction, resolves
// forwarded operands, detects load-use hazards and registers a single output slot.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [XLEN-1:0]      in_pc,
    output logic [4:0]           rs1_addr,
    output logic [4:0]           rs2_addr,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [NFWD-1:0]      fwd_en,
    input  logic [5*NFWD-1:0]    fwd_addr,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    input  logic                 ex_is_load,
    input  logic [4:0]           ex_rd,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_aluop,
    output logic [3:0]           out_alusel,
    output logic [XLEN-1:0]      out_op1,
    output logic [XLEN-1:0]      out_op2,
    output logic [XLEN-1:0]      out_store_data,
    output logic [XLEN-1:0]      out_pc,
    output logic [4:0]           out_rd,
    output logic                 out_wen,
    output logic                 out_mem_valid,
    output logic                 out_mem_rw,
    output logic                 out_illegal
);

    logic [6:0]      w_opc;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    dec_ctrl_t       w_ctrl;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [3:0]      w_alusel;
    logic            w_stall;
    logic            w_take;

    logic            r_valid;
    logic [7:0]      r_aluop;
    logic [3:0]      r_alusel;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_store_data;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rd;
    logic            r_wen;
    logic            r_mem_valid;
    logic            r_mem_rw;
    logic            r_illegal;

    assign w_opc    = in_inst[6:0];
    assign w_rd     = in_inst[11:7];
    assign w_funct3 = in_inst[14:12];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];
    assign w_ctrl   = decode_ctrl(w_opc, XLEN == 64);

    id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs1 (
        .i_addr     (rs1_addr),
        .i_fwd_en   (fwd_en),
        .i_fwd_addr (fwd_addr),
        .i_fwd_data (fwd_data),
        .i_rf_data  (rs1_data),
        .o_data     (w_rs1_val)
    );

    id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs2 (
        .i_addr     (rs2_addr),
        .i_fwd_en   (fwd_en),
        .i_fwd_addr (fwd_addr),
        .i_fwd_data (fwd_data),
        .i_rf_data  (rs2_data),
        .o_data     (w_rs2_val)
    );

    // Size casts of signed values sign-extend to XLEN for both RV32 and RV64
    always_comb begin
        w_imm = '0;
        case (w_ctrl.imm_type)
            IMM_I:   w_imm = XLEN'($signed(in_inst[31:20]));
            IMM_S:   w_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            IMM_U:   w_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            default: w_imm = '0;
        endcase
    end

    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        case (w_ctrl.op1_sel)
            OP1_RS1: w_op1 = w_rs1_val;
            OP1_PC:  w_op1 = in_pc;
            OP1_IMM: w_op1 = w_imm;
            default: w_op1 = '0;
        endcase
        case (w_ctrl.op2_sel)
            OP2_RS2: w_op2 = w_rs2_val;
            OP2_IMM: w_op2 = w_imm;
            default: w_op2 = '0;
        endcase
    end

    // Only the arithmetic-immediate shifts (funct3=101) carry inst[30] as SRA/SRL select
    always_comb begin
        w_alusel = 4'd0;
        if (w_ctrl.legal) begin
            case (w_opc)
                OPC_OP, OPC_OP_32:         w_alusel = {in_inst[30], w_funct3};
                OPC_OP_IMM, OPC_OP_IMM_32: w_alusel = (w_funct3 == 3'b101) ? {in_inst[30], w_funct3}
                                                                            : {1'b0, w_funct3};
                default:                   w_alusel = 4'd0;
            endcase
        end
    end

    assign w_stall = in_valid && ex_is_load && (ex_rd != 5'd0) &&
                     ((w_ctrl.use_rs1 && (ex_rd == rs1_addr)) ||
                      (w_ctrl.use_rs2 && (ex_rd == rs2_addr)));

    assign in_ready = rst_n && !w_stall && (!r_valid || out_ready);
    assign w_take   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_aluop      <= '0;
            r_alusel     <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_store_data <= '0;
            r_pc         <= '0;
            r_rd         <= '0;
            r_wen        <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!r_valid || out_ready) begin
            r_valid <= w_take;
            if (w_take) begin
                r_aluop      <= w_ctrl.aluop;
                r_alusel     <= w_alusel;
                r_op1        <= w_op1;
                r_op2        <= w_op2;
                r_store_data <= w_ctrl.store ? w_rs2_val : '0;
                r_pc         <= in_pc;
                r_rd         <= w_ctrl.writes_rd ? w_rd : 5'd0;
                r_wen        <= w_ctrl.writes_rd && (w_rd != 5'd0);
                r_mem_valid  <= w_ctrl.mem;
                r_mem_rw     <= w_ctrl.store;
                r_illegal    <= !w_ctrl.legal;
            end
        end
    end

    assign out_valid      = r_valid;
    assign out_aluop      = r_aluop;
    assign out_alusel     = r_alusel;
    assign out_op1        = r_op1;
    assign out_op2        = r_op2;
    assign out_store_data = r_store_data;
    assign out_pc         = r_pc;
    assign out_rd         = r_rd;
    assign out_wen        = r_wen;
    assign out_mem_valid  = r_mem_valid;
    assign out_mem_rw     = r_mem_rw;
    assign out_illegal    = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage (XLEN=64, NFWD=2) with hand-computed expectations.
module tb_id_stage;

    localparam int XLEN = 64;
    localparam int NFWD = 2;

    localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_SUB  = 32'h401081B3; // sub  x3,x1,x1
    localparam logic [31:0] I_ADDI = 32'hFFF08113; // addi x2,x1,-1
    localparam logic [31:0] I_SW   = 32'hFE20AE23; // sw   x2,-4(x1)
    localparam logic [31:0] I_LUI  = 32'h800002B7; // lui  x5,0x80000
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_inst;
    logic [XLEN-1:0]      in_pc;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [XLEN-1:0]      rs1_data;
    logic [XLEN-1:0]      rs2_data;
    logic [NFWD-1:0]      fwd_en;
    logic [5*NFWD-1:0]    fwd_addr;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic                 ex_is_load;
    logic [4:0]           ex_rd;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_aluop;
    logic [3:0]           out_alusel;
    logic [XLEN-1:0]      out_op1;
    logic [XLEN-1:0]      out_op2;
    logic [XLEN-1:0]      out_store_data;
    logic [XLEN-1:0]      out_pc;
    logic [4:0]           out_rd;
    logic                 out_wen;
    logic                 out_mem_valid;
    logic                 out_mem_rw;
    logic                 out_illegal;

    logic [XLEN-1:0] rf [32];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    id_stage #(.XLEN(XLEN), .NFWD(NFWD)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_aluop(out_aluop),
        .out_alusel(out_alusel), .out_op1(out_op1), .out_op2(out_op2),
        .out_store_data(out_store_data), .out_pc(out_pc), .out_rd(out_rd),
        .out_wen(out_wen), .out_mem_valid(out_mem_valid), .out_mem_rw(out_mem_rw),
        .out_illegal(out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 64'h0;
        rf[1] = 64'd5;
        rf[2] = 64'd7;
        rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 64'h1000;
        fwd_en = '0; fwd_addr = '0; fwd_data = '0;
        ex_is_load = 1'b0; ex_rd = 5'd0; flush = 1'b0; out_ready = 1'b1;

        // reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_op1", out_op1, 64'd0);
        chk("rst_out_aluop", 64'(out_aluop), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // add x3,x1,x2
        in_valid = 1'b1; in_inst = I_ADD;
        #1;
        chk("add_rs1_addr", 64'(rs1_addr), 64'd1);
        chk("add_rs2_addr", 64'(rs2_addr), 64'd2);
        chk("add_pre_valid", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_op1", out_op1, 64'd5);
        chk("add_op2", out_op2, 64'd7);
        chk("add_alusel", 64'(out_alusel), 64'h0);
        chk("add_rd", 64'(out_rd), 64'd3);
        chk("add_wen", 64'(out_wen), 64'd1);
        chk("add_aluop", 64'(out_aluop), 64'h01);
        chk("add_pc", out_pc, 64'h1000);

        // sub x3,x1,x1 with both forward ports matching x1: port 0 wins
        in_valid = 1'b1; in_inst = I_SUB;
        fwd_en = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {64'd200, 64'd100};
        tick();
        in_valid = 1'b0; fwd_en = 2'b00;
        chk("sub_op1", out_op1, 64'd100);
        chk("sub_op2", out_op2, 64'd100);
        chk("sub_alusel", 64'(out_alusel), 64'h8);

        // load-use hazard on x1
        ex_is_load = 1'b1; ex_rd = 5'd1;
        in_valid = 1'b1; in_inst = I_ADDI;
        #1;
        chk("lu_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("lu_out_valid", 64'(out_valid), 64'd0);
        ex_is_load = 1'b0;
        #1;
        chk("lu_release_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_op1", out_op1, 64'd5);
        chk("addi_op2", out_op2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", 64'(out_rd), 64'd2);

        // sw x2,-4(x1) then 3 cycles of backpressure
        in_valid = 1'b1; in_inst = I_SW;
        tick();
        out_ready = 1'b0; in_inst = I_ADD;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("sw_bp_in_ready", 64'(in_ready), 64'd0);
            tick();
            chk("sw_bp_valid", 64'(out_valid), 64'd1);
            chk("sw_bp_op1", out_op1, 64'd5);
            chk("sw_bp_op2", out_op2, 64'hFFFF_FFFF_FFFF_FFFC);
            chk("sw_bp_mem_rw", 64'(out_mem_rw), 64'd1);
            chk("sw_bp_store_data", out_store_data, 64'd7);
        end
        chk("sw_mem_valid", 64'(out_mem_valid), 64'd1);
        chk("sw_wen", 64'(out_wen), 64'd0);
        chk("sw_aluop", 64'(out_aluop), 64'h06);

        // flush beats backpressure
        flush = 1'b1;
        tick();
        chk("flush_held_valid", 64'(out_valid), 64'd0);
        // flush drops an accepted incoming instruction
        out_ready = 1'b1; in_valid = 1'b1; in_inst = I_ADD;
        tick();
        chk("flush_in_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;

        // illegal opcode 0x7F
        in_inst = I_BAD;
        tick();
        chk("bad_valid", 64'(out_valid), 64'd1);
        chk("bad_illegal", 64'(out_illegal), 64'd1);
        chk("bad_wen", 64'(out_wen), 64'd0);
        chk("bad_mem_valid", 64'(out_mem_valid), 64'd0);

        // lui x5,0x80000
        in_inst = I_LUI;
        tick();
        chk("lui_op1", out_op1, 64'hFFFF_FFFF_8000_0000);
        chk("lui_op2", out_op2, 64'd0);
        chk("lui_rd", 64'(out_rd), 64'd5);
        chk("lui_wen", 64'(out_wen), 64'd1);
        chk("lui_illegal", 64'(out_illegal), 64'd0);

        // asynchronous reset mid-stream
        in_inst = I_ADD;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_op1", out_op1, 64'd0);
        chk("arst_wen", 64'(out_wen), 64'd0);
        chk("arst_rd", 64'(out_rd), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("arst_discard", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath/operand width (32 or 64).
REQ-002 SHALL have parameter NFWD, default 2, meaning number of forwarding ports; index 0 is the youngest.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, in_inst input 32, in_pc input XLEN: upstream instruction handshake.
REQ-006 SHALL have ports rs1_addr output 5, rs2_addr output 5, rs1_data input XLEN, rs2_data input XLEN: combinational regfile read.
REQ-007 SHALL have ports fwd_en input NFWD, fwd_addr input 5*NFWD, fwd_data input XLEN*NFWD: packed forwarding sources.
REQ-008 SHALL have ports ex_is_load input 1, ex_rd input 5: load currently in EX, for load-use detection.
REQ-009 SHALL have port flush input 1: kill held and incoming instruction.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, out_aluop output 8, out_alusel output 4, out_op1/out_op2/out_store_data/out_pc output XLEN, out_rd output 5, out_wen/out_mem_valid/out_mem_rw/out_illegal output 1.

Function
REQ-011 SHALL register all out_* signals in one output stage; latency in_valid&&in_ready to out_valid is exactly 1 cycle.
REQ-012 SHALL assert in_ready = !stall && (!out_valid || out_ready); transfer on in_valid&&in_ready; hold all out_* stable while out_valid&&!out_ready.
REQ-013 SHALL decode OP, OP-32, OP-IMM, OP-IMM-32, LUI, AUIPC, LOAD, STORE; OP-32/OP-IMM-32 only when XLEN==64; any other opcode sets out_illegal=1, out_wen=0, out_mem_valid=0.
REQ-014 SHALL set out_alusel = {inst[30], funct3} for OP/OP-32 and for OP-IMM shifts with funct3=101; {0, funct3} for other OP-IMM; 0 otherwise.
REQ-015 SHALL set out_aluop from package codes per class; bit 7 set for *-32 word ops.
REQ-016 SHALL generate I/S/U immediates sign-extended to XLEN; LUI op1=U-imm, op2=0; AUIPC op1=in_pc, op2=U-imm; LOAD/OP-IMM op2=I-imm; STORE op2=S-imm, out_store_data=forwarded rs2.
REQ-017 SHALL drive rs1_addr/rs2_addr from in_inst[19:15]/[24:20] combinationally (not through prior-cycle state).
REQ-018 SHALL resolve each source: addr 0 -> 0; else lowest index k with fwd_en[k] && fwd_addr[k]==addr -> fwd_data[k]; else regfile data.
REQ-019 SHALL raise stall when in_valid && ex_is_load && ex_rd!=0 && ex_rd equals a source the instruction actually uses; stall deasserts in_ready, and out_valid drops to 0 on the next edge if out_ready=1.
REQ-020 SHALL set out_wen=1 only for valid register-writing classes with rd!=0; out_mem_valid=1 for LOAD/STORE; out_mem_rw=1 for STORE.
REQ-021 SHALL on flush clear out_valid next edge, drop any incoming transfer, and take priority over stall and out_ready backpressure.

Reset
REQ-022 SHALL on rst_n=0 asynchronously clear out_valid, out_wen, out_mem_valid, out_mem_rw, out_illegal and zero all other out_* registers.
REQ-023 SHALL keep in_ready=0 while rst_n=0; reset mid-transfer discards the instruction.

Structure
REQ-024 SHALL place opcode constants, aluop class codes and immediate-type enum in a shared riscv-defines package/include.
REQ-025 SHALL use one sub-module id_fwd_mux (NFWD-way priority forwarding select), instantiated once per source.

Verification
REQ-026 SHALL test add x3,x1,x2 with x1=5, x2=7, no forwarding -> one cycle later out_op1=5, out_op2=7, out_alusel=0000, out_rd=3, out_wen=1.
REQ-027 SHALL test sub x3,x1,x1 with fwd0 {x1,100} and fwd1 {x1,200} -> out_op1=out_op2=100, out_alusel=1000.
REQ-028 SHALL test ex_is_load=1, ex_rd=1, then addi x2,x1,-1 -> in_ready=0 for one cycle, out_valid=0; after release out_op2=all ones.
REQ-029 SHALL test out_ready=0 for 3 cycles with valid sw x2,-4(x1) -> outputs stable, in_ready=0; out_mem_rw=1, out_op2=-4.
REQ-030 SHALL test flush with out_valid=1 and out_ready=0 -> out_valid=0 next cycle; also rst_n low mid-stream -> all outputs zero immediately.
REQ-031 SHALL test opcode 0x7F -> out_illegal=1, out_wen=0; lui x5,0x80000 at XLEN=64 -> out_op1=0xFFFFFFFF80000000.
